// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle data_valid / frame_err strobes.
// Latency ~9.5 bit times from start edge to strobe; no backpressure (byte is overwritten by the next one).
// Build option: define UART_RX_FRAMING_ERR_EN to discard bytes with a bad stop bit and pulse frame_err.
module uart_rx #(
    parameter int bd_divider = 2500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err
);

    localparam logic [15:0] BIT_LAST  = 16'(bd_divider - 1);
    localparam logic [15:0] HALF_LAST = 16'(bd_divider / 2 - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_err_q, frame_err_d;

    always_comb begin
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line half a bit in so short low glitches are dropped.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = 16'd0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (rx_s_q) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
`ifdef UART_RX_FRAMING_ERR_EN
                        frame_err_d  = 1'b1;
`else
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
`endif
                        state_d      = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RECOVER: begin
                // A held-low line (break) must go high before a new start is accepted.
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            cnt_q        <= 16'd0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at bd_divider=16: table vectors, hand corner cases, random frames vs a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;

    uart_rx #(.bd_divider(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         tail_low;
        int         gap;
        int         exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] exp_dout;
    logic [7:0] last_dout;
    logic       prev_valid;
    logic       rst_seen;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         t_last_valid = -1;
    int         ferr_seen = 0;
    int         t_fall;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference: bits[0]=start, bits[8:1]=data LSB first, bits[9]=stop.
    function automatic void model_frame(input logic [9:0] bits);
        ev_t e;
        e.data = bits[8:1];
        e.ferr = 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
        if (!bits[9]) e.ferr = 1'b1;
`endif
        if (!e.ferr) exp_dout = e.data;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst || rst_seen) begin
            last_dout  = data_out;
            prev_valid = 1'b0;
        end else begin
            if (data_valid || frame_err) begin
                check("strobe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
                check("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("strobe_kind", {31'd0, frame_err}, {31'd0, mon_e.ferr});
                    if (data_valid) check("rx_byte", {24'd0, data_out}, {24'd0, mon_e.data});
                end
            end
            if (frame_err) ferr_seen++;
            if (data_valid) begin
                check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
                t_last_valid = cyc;
            end else begin
                check("dout_hold", {24'd0, data_out}, {24'd0, last_dout});
            end
            last_dout  = data_out;
            prev_valid = data_valid;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int tail_low, input int gap);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        model_frame(bits);
        t_fall = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            wait_cycles(BD);
        end
        if (tail_low > 0) begin
            rx = 1'b0;
            wait_cycles(tail_low);
        end
        rx = 1'b1;
        wait_cycles(gap);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 400) begin
            wait_cycles(1);
            k++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int lat;
        int fs;
        logic [9:0] bits;

        vecs[0] = '{8'h00, 1'b1, 0, 0,  0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 0, 0,  0, 8'hFF};
        vecs[2] = '{8'h3C, 1'b1, 0, 20, 0, 8'h3C};
`ifdef UART_RX_FRAMING_ERR_EN
        vecs[3] = '{8'h81, 1'b0, 40, 30, 1, 8'h3C};
`else
        vecs[3] = '{8'h81, 1'b0, 40, 30, 0, 8'h81};
`endif
        vecs[4] = '{8'h55, 1'b1, 0, 20, 0, 8'h55};
        vecs[5] = '{8'h01, 1'b1, 0, 0,  0, 8'h01};
        vecs[6] = '{8'h80, 1'b1, 0, 20, 0, 8'h80};

        rst = 1'b1;
        rx  = 1'b1;
        exp_dout = 8'h00;
        wait_cycles(3);
        check("reset_dout",  {24'd0, data_out}, 32'd0);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_ferr",  {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        wait_cycles(20);

        // Clean 0xA5 with latency window
        send_frame(8'hA5, 1'b1, 0, 10);
        drain("drain_a5");
        lat = t_last_valid - t_fall;
        check("a5_latency", {31'd0, lat >= 150 && lat <= 160}, 32'd1);
        check("a5_dout", {24'd0, data_out}, 32'h0000_00A5);

        foreach (vecs[i]) begin
            fs = ferr_seen;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].tail_low, vecs[i].gap);
            drain("drain_vec");
            check("vec_dout", {24'd0, data_out}, {24'd0, vecs[i].exp_dout});
            check("vec_ferr_count", ferr_seen - fs, vecs[i].exp_ferr);
        end

        // Short low glitch is rejected, then a real frame follows
        rx = 1'b0;
        wait_cycles(5);
        rx = 1'b1;
        wait_cycles(30);
        check("glitch_no_strobe", exp_q.size(), 32'd0);
        send_frame(8'h55, 1'b1, 0, 10);
        drain("drain_after_glitch");
        check("glitch_then_55", {24'd0, data_out}, 32'h0000_0055);

        // Reset pulse during bit 4 of 0xC3; sender aborts the frame
        bits = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = bits[i];
            wait_cycles(BD);
        end
        rx = bits[5];
        wait_cycles(BD / 2);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        rx  = 1'b1;
        exp_dout = 8'h00;
        check("midrst_dout",  {24'd0, data_out}, 32'd0);
        check("midrst_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_ferr",  {31'd0, frame_err}, 32'd0);
        wait_cycles(200);
        check("midrst_dout_idle", {24'd0, data_out}, 32'd0);
        send_frame(8'h7E, 1'b1, 0, 10);
        drain("drain_7e");
        check("after_rst_7e", {24'd0, data_out}, 32'h0000_007E);

        // Random traffic against the frame model
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                rx = 1'b0;
                wait_cycles($urandom_range(1, 6));
                rx = 1'b1;
                wait_cycles(20);
            end else begin
                logic stop;
                int   tl, gp;
                stop = ($urandom_range(0, 4) != 0);
                tl   = stop ? 0 : $urandom_range(0, 40);
                gp   = stop ? $urandom_range(0, 15) : $urandom_range(4, 15);
                send_frame(8'($urandom), stop, tl, gp);
            end
            drain("drain_rand");
            check("rand_dout", {24'd0, data_out}, {24'd0, exp_dout});
        end

        wait_cycles(50);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: bd_divider, default 2500, clock cycles per bit (clock_frequency / baudrate); legal range 4..65535.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port: data_out  output  8  last received byte.
REQ-006 SHALL have port: data_valid  output  1  one-cycle strobe, data_out valid.
REQ-007 SHALL have port: frame_err  output  1  one-cycle strobe on bad stop bit.
REQ-008 SHALL use one clock only; reset is synchronous and active-high.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all decisions below use the synchronized value (rx_s).
REQ-010 SHALL implement states IDLE, START, DATA, STOP, RECOVER with a 16-bit cycle counter and a 3-bit bit index.
REQ-011 IDLE: counter and index held at 0; rx_s=0 -> START.
REQ-012 START: count to bd_divider/2-1 (integer divide), then sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no strobe).
REQ-013 DATA: every bd_divider cycles sample rx_s into shift register bit [index], LSB first; after index 7 sampled -> STOP with index cleared.
REQ-014 STOP: after bd_divider cycles sample rx_s; 1 -> IDLE with byte accepted; 0 -> RECOVER.
REQ-015 On byte accepted, data_out SHALL load the shift register and data_valid SHALL be high for exactly the next cycle.
REQ-016 data_out SHALL hold its value until the next accepted byte; it SHALL NOT change on a glitch or framing error.
REQ-017 RECOVER: remain until rx_s=1, then -> IDLE; a line held low (break) SHALL NOT start a new frame.
REQ-018 Back-to-back frames (stop bit directly followed by next start bit) SHALL all be received without loss.
REQ-019 data_valid and frame_err SHALL never be high in the same cycle.
REQ-020 Unreachable state encodings SHALL return to IDLE on the next cycle.

Reset
REQ-021 With rst high at a clock edge: state=IDLE, counter=0, index=0, shift register=0, synchronizer flops=1, data_out=8'h00, data_valid=0, frame_err=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no strobe; reception resumes at the next falling edge after rst deasserts.

Configuration
REQ-023 Macro UART_RX_FRAMING_ERR_EN SHALL select framing-error handling.
REQ-024 Defined: STOP sample 0 pulses frame_err for one cycle, discards the byte (no data_valid, data_out unchanged), then enters RECOVER.
REQ-025 Undefined: frame_err tied 0; a STOP sample of 0 still accepts the byte (data_valid pulses, data_out updated), then enters RECOVER.

Verification (bd_divider=16)
REQ-026 Send 0xA5 as a clean 8N1 frame -> data_out=8'hA5, data_valid high exactly 1 cycle, 150..160 cycles after the rx falling edge.
REQ-027 Send 0x00, 0xFF, 0x3C back-to-back -> three data_valid pulses with data_out 00, FF, 3C in order, frame_err never high.
REQ-028 Pull rx low for 5 cycles in IDLE -> no data_valid, no frame_err; a following 0x55 frame is received correctly.
REQ-029 Send 0x81 with stop bit forced 0, then hold rx low 40 cycles -> with macro: frame_err 1 pulse, data_out unchanged, no new frame while low; without macro: data_valid 1 pulse with data_out=8'h81.
REQ-030 Assert rst for 1 cycle during bit 4 of 0xC3 -> no strobe, outputs at reset values; the next frame 0x7E yields data_out=8'h7E.
